// File: rtl/canny_lb_pkg.sv
// rtl/canny_lb_pkg.sv - shared widths and slice helpers for the Canny line buffer
package canny_lb_pkg;

    localparam int DW_DEFAULT = 3;

    function automatic int xw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int yw(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    // LSB of slice r inside a packed DW*ROWS column
    function automatic int slice_lsb(input int r, input int dw);
        return r * dw;
    endfunction

endpackage

// File: rtl/lb_line_store.sv
// rtl/lb_line_store.sv - single-port circular line RAM, read-before-write at one address
module lb_line_store #(
    parameter int DW    = 3,
    parameter int WIDTH = 320,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [WIDTH];

    // rdata is the pre-write content, so the chain shifts one row per accept
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_window.sv
// rtl/line_buffer_window.sv - streaming ROWS-tall column window; LB_ZERO_PAD_EN selects top zero padding
module line_buffer_window
    import canny_lb_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ROWS   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DW-1:0]              in_pixel,
    output logic                       out_valid,
    output logic [DW*ROWS-1:0]         out_col,
    output logic [$clog2(WIDTH)-1:0]   out_x,
    output logic [$clog2(HEIGHT)-1:0]  out_y,
    output logic                       out_primed
);

    localparam int XW = xw(WIDTH);
    localparam int YW = yw(HEIGHT);

    logic [XW-1:0]      x, x_eff, x_next;
    logic [YW-1:0]      y, y_eff, y_next;
    logic [DW-1:0]      rd [ROWS-1];
    logic [DW*ROWS-1:0] col_next;
    logic               primed_next;

    // in_sof forces this pixel to the frame origin
    always_comb begin
        x_eff = in_sof ? '0 : x;
        y_eff = in_sof ? '0 : y;
        x_next = x_eff + XW'(1);
        y_next = y_eff;
        if (x_eff == XW'(WIDTH - 1)) begin
            x_next = '0;
            y_next = (y_eff == YW'(HEIGHT - 1)) ? '0 : y_eff + YW'(1);
        end
        primed_next = (int'(y_eff) >= ROWS - 1);
    end

    for (genvar k = 0; k < ROWS - 1; k++) begin : g_store
        logic [DW-1:0] wdata;
        if (k == ROWS - 2) begin : g_last
            assign wdata = in_pixel;
        end else begin : g_mid
            assign wdata = rd[k+1];
        end
        lb_line_store #(.DW(DW), .WIDTH(WIDTH), .AW(XW)) u_store (
            .clk   (clk),
            .en    (in_valid),
            .addr  (x_eff),
            .wdata (wdata),
            .rdata (rd[k])
        );
    end

    always_comb begin
        col_next = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            col_next[slice_lsb(r, DW) +: DW] = rd[r];
`ifdef LB_ZERO_PAD_EN
            if (int'(y_eff) < ROWS - 1 - r) begin
                col_next[slice_lsb(r, DW) +: DW] = '0;
            end
`endif
        end
        col_next[slice_lsb(ROWS - 1, DW) +: DW] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_primed <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                x          <= x_next;
                y          <= y_next;
                out_col    <= col_next;
                out_x      <= x_eff;
                out_y      <= y_eff;
                out_primed <= primed_next;
`ifdef LB_ZERO_PAD_EN
                out_valid  <= 1'b1;
`else
                out_valid  <= primed_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_window.sv
// tb/tb_line_buffer_window.sv - directed bench with image-array reference model
module tb_line_buffer_window;

    localparam int DW = 3, WIDTH = 4, HEIGHT = 5, ROWS = 3;
`ifdef LB_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_sof = 1'b0;
    logic [DW-1:0]       in_pixel = '0;
    logic                out_valid;
    logic [DW*ROWS-1:0]  out_col;
    logic [1:0]          out_x;
    logic [2:0]          out_y;
    logic                out_primed;

    line_buffer_window #(.DW(DW), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_primed (out_primed)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the frame as a 2-D image; a column is read straight out of it
    logic [DW-1:0]      img [HEIGHT][WIDTH];
    int                 mx, my, xe, ye, ry;
    bit                 e_valid, e_primed, col_known;
    logic [DW*ROWS-1:0] e_col;
    int                 e_x, e_y;

    always @(posedge clk) begin
        if (rst) begin
            mx = 0; my = 0;
            e_valid = 0; e_primed = 0; e_col = '0; e_x = 0; e_y = 0;
            col_known = 1;
        end else if (in_valid) begin
            xe = in_sof ? 0 : mx;
            ye = in_sof ? 0 : my;
            img[ye][xe] = in_pixel;
            e_col = '0;
            for (int r = 0; r < ROWS; r++) begin
                ry = ye - (ROWS - 1 - r);
                if (ry >= 0) e_col[r*DW +: DW] = img[ry][xe];
            end
            e_x = xe;
            e_y = ye;
            e_primed = (ye >= ROWS - 1);
            e_valid = PAD || e_primed;
            col_known = e_valid;
            mx = (xe + 1) % WIDTH;
            my = (xe == WIDTH - 1) ? (ye + 1) % HEIGHT : ye;
        end else begin
            e_valid = 0;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(out_valid), 32'(e_valid));
        chk("x", 32'(out_x), e_x);
        chk("y", 32'(out_y), e_y);
        chk("primed", 32'(out_primed), 32'(e_primed));
        if (col_known) chk("col", 32'(out_col), 32'(e_col));
    end

    task automatic step(input bit v, input bit s, input int p);
        in_valid = v;
        in_sof   = s;
        in_pixel = DW'(p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Sends pixels (x0,y0)..(x1,y1) in raster order; mode 0 -> y+1, mode 1 -> x/y mix
    task automatic run(input int mode, input bit gaps, input bit sof_first,
                       input int x0, input int y0, input int x1, input int y1);
        int px, py;
        for (int i = y0 * WIDTH + x0; i <= y1 * WIDTH + x1; i++) begin
            px = i % WIDTH;
            py = i / WIDTH;
            step(1'b1, sof_first && (i == y0 * WIDTH + x0),
                 (mode == 0) ? py + 1 : (px * 3 + py * 5 + 1) % 8);
            if (gaps) step(1'b0, 1'b0, 7);
        end
    endtask

    task automatic chk_col_021(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 1);
        chk({nm, "_col"}, 32'(out_col), 32'h0D1);
        chk({nm, "_x"}, 32'(out_x), 0);
        chk({nm, "_y"}, 32'(out_y), 2);
        chk({nm, "_primed"}, 32'(out_primed), 1);
    endtask

    initial begin
        rst = 1'b1;
        step(1'b1, 1'b0, 5);
        step(1'b0, 1'b0, 0);
        chk("rst_col", 32'(out_col), 0);
        chk("rst_valid", 32'(out_valid), 0);
        rst = 1'b0;

        // continuous frame
        run(0, 0, 1, 0, 0, 0, 0);
        chk("t1_p00_valid", 32'(out_valid), 32'(PAD));
`ifdef LB_ZERO_PAD_EN
        chk("t1_p00_col", 32'(out_col), 32'h040);
        chk("t1_p00_primed", 32'(out_primed), 0);
        run(0, 0, 0, 1, 0, 1, 1);
        chk("t1_p11_col", 32'(out_col), 32'h088);
        run(0, 0, 0, 2, 1, 0, 2);
`else
        run(0, 0, 0, 1, 0, 0, 2);
`endif
        chk_col_021("t1");
        run(0, 0, 0, 1, 2, 3, 4);

        // same stream with idle gaps
        run(0, 1, 1, 0, 0, 0, 2);
        chk("t2_hold_valid", 32'(out_valid), 0);
        chk("t2_hold_col", 32'(out_col), 32'h0D1);
        chk("t2_hold_y", 32'(out_y), 2);
        run(0, 1, 0, 1, 2, 3, 4);

        // mid-frame restart at (2,3)
        run(1, 0, 1, 0, 0, 1, 3);
        run(1, 0, 1, 0, 0, 3, 1);
        chk("t3_withheld", 32'(out_valid), 32'(PAD));
        run(1, 0, 0, 0, 2, 0, 2);
        chk("t3_first_valid", 32'(out_valid), 1);
        chk("t3_first_x", 32'(out_x), 0);
        chk("t3_first_y", 32'(out_y), 2);
        run(1, 0, 0, 1, 2, 3, 4);

        // reset during row 3 with a pixel offered
        run(1, 0, 1, 0, 0, 1, 3);
        rst = 1'b1;
        step(1'b1, 1'b0, 6);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_col", 32'(out_col), 0);
        chk("t4_x", 32'(out_x), 0);
        chk("t4_y", 32'(out_y), 0);
        chk("t4_primed", 32'(out_primed), 0);
        rst = 1'b0;
        run(0, 0, 1, 0, 0, 0, 2);
        chk_col_021("t4r");
        run(0, 0, 0, 1, 2, 3, 4);

        // frame wrap without in_sof
        run(1, 0, 0, 0, 0, 0, 0);
        chk("t5_wrap_x", 32'(out_x), 0);
        chk("t5_wrap_y", 32'(out_y), 0);
        chk("t5_wrap_valid", 32'(out_valid), 32'(PAD));
        run(1, 0, 0, 1, 0, 3, 4);
        run(1, 0, 0, 0, 0, 3, 2);

        step(1'b0, 1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
